simd_addsub_pipe: RTL



---
 rtl/simd_addsub_pkg.sv | 26 ++
 rtl/addsub_seg.sv | 16 +
 rtl/simd_addsub_pipe.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/simd_addsub_pkg.sv
// Shared constants and lane-boundary helper for the SIMD add/sub pipeline.
package simd_addsub_pkg;

    localparam int unsigned WIDTH_DEF  = 64;
    localparam int unsigned SEG_W_DEF  = 16;
    localparam int unsigned MAX_SEG    = 32;

    localparam int unsigned MODE_1LANE = 0;
    localparam int unsigned MODE_2LANE = 1;
    localparam int unsigned MODE_4LANE = 2;

    // Bit k set when segment k is the least-significant segment of its lane.
    function automatic logic [MAX_SEG-1:0] lane_start_mask(input int unsigned mode,
                                                           input int unsigned nseg);
        logic [MAX_SEG-1:0] m;
        int unsigned segs;
        m    = '0;
        segs = nseg >> mode;
        if (segs == 0) segs = 1;
        for (int unsigned k = 0; k < MAX_SEG; k++) begin
            if (k < nseg && (k & (segs - 1)) == 0) m[k] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// One carry-select segment: sums and carries for carry-in 0 and carry-in 1.
module addsub_seg #(
    parameter int unsigned SEG_W = 16
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    output logic [SEG_W-1:0] sum0,
    output logic [SEG_W-1:0] sum1,
    output logic             c0,
    output logic             c1
);

    assign {c0, sum0} = {1'b0, a} + {1'b0, b};
    assign {c1, sum1} = {1'b0, a} + {1'b0, b} + (SEG_W + 1)'(1);

endmodule

// File: rtl/simd_addsub_pipe.sv
// Two-stage SIMD add/subtract with per-lane split and valid/ready handshake.
// Optional signed saturation and overflow flags under SIMD_ADDSUB_SAT_EN.
module simd_addsub_pipe
    import simd_addsub_pkg::*;
#(
    parameter  int unsigned WIDTH    = WIDTH_DEF,
    parameter  int unsigned SEG_W    = SEG_W_DEF,
    localparam int unsigned NSEG     = WIDTH / SEG_W,
    localparam int unsigned LOG_NSEG = $clog2(NSEG),
    localparam int unsigned MW       = LOG_NSEG + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [MW-1:0]    mode,
    input  logic [NSEG-1:0]  sub,
`ifdef SIMD_ADDSUB_SAT_EN
    input  logic             sat,
    output logic [NSEG-1:0]  ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [NSEG-1:0]  cout
);

    localparam int unsigned LW = LOG_NSEG;

    logic                       s2_accept, s1_load, s1_valid;
    logic [MW-1:0]              mode_c;
    logic [WIDTH-1:0]           b_eff;
    logic [NSEG-1:0][SEG_W-1:0] seg_sum0, seg_sum1;
    logic [NSEG-1:0]            seg_c0, seg_c1;

    logic [NSEG-1:0][SEG_W-1:0] s1_sum0, s1_sum1;
    logic [NSEG-1:0]            s1_c0, s1_c1, s1_sub;
    logic [MW-1:0]              s1_mode;

    logic [MAX_SEG-1:0]         start_mask;
    logic [NSEG:0]              start;
    logic [WIDTH-1:0]           sum_d;
    logic [NSEG-1:0]            cout_d;

    assign s2_accept = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_accept;
    assign s1_load   = in_valid && in_ready;
    assign mode_c    = (mode > MW'(LOG_NSEG)) ? MW'(LOG_NSEG) : mode;

    // Lane k applies sub[k]; invert b per segment according to its owning lane.
    always_comb begin
        logic [LW-1:0] ln;
        ln    = '0;
        b_eff = '0;
        for (int unsigned k = 0; k < NSEG; k++) begin
            ln = LW'(k >> (LOG_NSEG - 32'(mode_c)));
            b_eff[k*SEG_W +: SEG_W] = sub[ln] ? ~b[k*SEG_W +: SEG_W] : b[k*SEG_W +: SEG_W];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        addsub_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .a    (a[k*SEG_W +: SEG_W]),
            .b    (b_eff[k*SEG_W +: SEG_W]),
            .sum0 (seg_sum0[k]),
            .sum1 (seg_sum1[k]),
            .c0   (seg_c0[k]),
            .c1   (seg_c1[k])
        );
    end

`ifdef SIMD_ADDSUB_SAT_EN
    logic            s1_sat;
    logic [NSEG-1:0] s1_a_msb, s1_b_msb, ovf_d, pos_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sum0  <= '0;
            s1_sum1  <= '0;
            s1_c0    <= '0;
            s1_c1    <= '0;
            s1_sub   <= '0;
            s1_mode  <= '0;
`ifdef SIMD_ADDSUB_SAT_EN
            s1_sat   <= 1'b0;
            s1_a_msb <= '0;
            s1_b_msb <= '0;
`endif
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s1_load) begin
                s1_sum0 <= seg_sum0;
                s1_sum1 <= seg_sum1;
                s1_c0   <= seg_c0;
                s1_c1   <= seg_c1;
                s1_sub  <= sub;
                s1_mode <= mode_c;
`ifdef SIMD_ADDSUB_SAT_EN
                s1_sat  <= sat;
                for (int unsigned k = 0; k < NSEG; k++) begin
                    s1_a_msb[k] <= a[k*SEG_W + SEG_W - 1];
                    s1_b_msb[k] <= b_eff[k*SEG_W + SEG_W - 1];
                end
`endif
            end
        end
    end

    assign start_mask = lane_start_mask(32'(s1_mode), NSEG);

    // Ripple the carry-select choice within each lane; lane starts take the sub bit.
    always_comb begin
        logic [LW-1:0]    ln;
        logic             carry, cin;
        logic [SEG_W-1:0] res;
        ln     = '0;
        carry  = 1'b0;
        cin    = 1'b0;
        res    = '0;
        start  = {1'b1, start_mask[NSEG-1:0]};
        sum_d  = '0;
        cout_d = '0;
`ifdef SIMD_ADDSUB_SAT_EN
        ovf_d  = '0;
        pos_d  = '0;
`endif
        for (int unsigned k = 0; k < NSEG; k++) begin
            ln    = LW'(k >> (LOG_NSEG - 32'(s1_mode)));
            cin   = start[k] ? s1_sub[ln] : carry;
            res   = cin ? s1_sum1[k] : s1_sum0[k];
            carry = cin ? s1_c1[k] : s1_c0[k];
            sum_d[k*SEG_W +: SEG_W] = res;
            if (start[k+1]) begin
                cout_d[ln] = carry;
`ifdef SIMD_ADDSUB_SAT_EN
                ovf_d[ln] = (s1_a_msb[k] == s1_b_msb[k]) && (res[SEG_W-1] != s1_a_msb[k]);
                pos_d[ln] = !s1_a_msb[k];
`endif
            end
        end
`ifdef SIMD_ADDSUB_SAT_EN
        for (int unsigned k = 0; k < NSEG; k++) begin
            ln = LW'(k >> (LOG_NSEG - 32'(s1_mode)));
            if (s1_sat && ovf_d[ln]) begin
                if (pos_d[ln]) begin
                    sum_d[k*SEG_W +: SEG_W] = start[k+1] ? {1'b0, {(SEG_W-1){1'b1}}} : '1;
                end else begin
                    sum_d[k*SEG_W +: SEG_W] = start[k+1] ? {1'b1, {(SEG_W-1){1'b0}}} : '0;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= '0;
`ifdef SIMD_ADDSUB_SAT_EN
            ovf       <= '0;
`endif
        end else if (s2_accept) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum  <= sum_d;
                cout <= cout_d;
`ifdef SIMD_ADDSUB_SAT_EN
                ovf  <= ovf_d;
`endif
            end
        end
    end

endmodule
